// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keycode_rx
// Description : PS/2 keyboard receiver. Conditions the raw ps2_clk/ps2_data
//               lines, deserialises 11-bit device-to-host frames, strips the
//               0xE0 (extended) and 0xF0 (break) prefixes and emits one
//               single-cycle key_valid strobe per make-code.
// Options     : PS2_PARITY_CHECK_EN - when defined, a bad odd-parity bit
//               fails the frame; when undefined the parity bit is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keycode_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_valid,
  output logic       frame_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Filter counter must hold FILTER_LEN-1; +1 keeps the width non-zero for
  // a FILTER_LEN of 1.
  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam logic [c_FILT_W-1:0] c_FILT_MAX = c_FILT_W'(FILTER_LEN - 1);

  // Timeout terminal count in system clocks; the counter is sized so it can
  // reach the terminal count without wrapping.
  localparam int c_TO_TERM = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int c_TO_W    = $clog2(c_TO_TERM + 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(c_TO_TERM);

  localparam logic [7:0] c_BYTE_EXT = 8'hE0;
  localparam logic [7:0] c_BYTE_BRK = 8'hF0;

  // Bit count value held while the stop bit is being received: start bit
  // sets the count to 1, so the 11th bit arrives when the count reads 10.
  localparam logic [3:0] c_LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic                r_clk_s1;
  logic                r_clk_s2;
  logic                r_dat_s1;
  logic                r_dat_s2;
  logic                r_filt_clk;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                r_strobe;

  // Two-flop synchronisers; both lines idle high so they reset high too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter on the clock: flip the filtered level only after the
  // synchronised clock has disagreed with it for FILTER_LEN cycles in a row,
  // and raise a one-cycle sample strobe on every filtered falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_clk_s2 != r_filt_clk) begin
        if (r_filt_cnt == c_FILT_MAX) begin
          r_filt_clk <= r_clk_s2;
          r_filt_cnt <= '0;
          r_strobe   <= r_filt_clk;   // only a 1 -> 0 transition samples
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [3:0]          r_bit_cnt;
  logic [9:0]          r_shift;     // [7:0] data, [8] parity, [9] stop
  logic [c_TO_W-1:0]   r_to_cnt;

  logic w_timeout;
  logic w_check;
  logic w_parity_ok;
  logic w_good;
  logic w_bad;

  assign w_timeout = (r_state == S_RECV) && !r_strobe && (r_to_cnt == c_TO_MAX);
  assign w_check   = (r_state == S_CHECK);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit hold an odd number of ones.
  assign w_parity_ok = ^r_shift[8:0];
`else
  assign w_parity_ok = 1'b1;
`endif

  // The start bit was already required to be 0 to leave IDLE, so CHECK only
  // has to look at the stop bit and parity.
  assign w_good = w_check && r_shift[9] && w_parity_ok;
  assign w_bad  = (w_check && !w_good) || w_timeout;

  // Frame sequencing: hunt for a start bit, shift in ten more bits LSB first,
  // spend one cycle in CHECK, and abandon a frame whose clock stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_to_cnt  <= '0;
          r_bit_cnt <= '0;
          if (r_strobe && !r_dat_s2) begin
            r_state   <= S_RECV;
            r_bit_cnt <= 4'd1;
          end
        end
        S_RECV: begin
          if (r_strobe) begin
            r_shift   <= {r_dat_s2, r_shift[9:1]};
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == c_LAST_BIT) begin
              r_state <= S_CHECK;
            end
          end else if (r_to_cnt == c_TO_MAX) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Protocol layer
  // --------------------------------------------------------------------------
  logic r_brk;
  logic r_ext;

  // Turn good bytes into make-code strobes: E0/F0 only set flags, a byte
  // after F0 is a release and is swallowed, anything else is a make-code.
  // Any frame error forgets a half-seen prefix sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (w_bad) begin
        frame_err <= 1'b1;
        r_brk     <= 1'b0;
        r_ext     <= 1'b0;
      end else if (w_good) begin
        if (r_shift[7:0] == c_BYTE_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shift[7:0] == c_BYTE_BRK) begin
          r_brk <= 1'b1;
        end else if (r_brk) begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else begin
          key_code     <= r_shift[7:0];
          key_extended <= r_ext;
          key_valid    <= 1'b1;
          r_ext        <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keycode_rx
// Description : Scoreboard bench for ps2_keycode_rx. Frames are bit-banged on
//               ps2_clk/ps2_data; expected strobes are queued at stimulus time
//               and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_rx;

  localparam int c_CLK_HZ     = 1_000_000;
  localparam int c_FILTER_LEN = 8;
  localparam int c_TIMEOUT_US = 200;   // 200-cycle timeout at this CLK_HZ

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_valid;
  logic       frame_err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp;
  int   n_err;

  ps2_keycode_rx #(
    .CLK_HZ     (c_CLK_HZ),
    .FILTER_LEN (c_FILTER_LEN),
    .TIMEOUT_US (c_TIMEOUT_US)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_valid    (key_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison used by the stimulus process.
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_key(input logic [7:0] code, input logic ext);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = code;
    e.ext    = ext;
    q_exp.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    e.ext    = 1'b0;
    q_exp.push_back(e);
  endtask

  // Bit-bang the first nbits of a frame: 80-cycle bits, data set up while the
  // clock is high, 40-cycle low phase.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (20) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (40) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
    end
    if (nbits == 11) begin
      ps2_data = 1'b1;
      repeat (100) @(posedge clk);
    end
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (q_exp.size() == 0) break;
      @(posedge clk);
    end
    check({"drain_", name}, q_exp.size(), 0);
  endtask

  // Monitor: every output strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (key_valid || frame_err) begin
      n_cmp++;
      if (key_valid && frame_err) begin
        n_err++;
        $display("FAIL both_strobes: key_valid=1 frame_err=1 at %0t", $time);
      end else if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: key_valid=%0b frame_err=%0b code=0x%0h at %0t",
                 key_valid, frame_err, key_code, $time);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        if (e.is_err != frame_err ||
            (!e.is_err && (key_code != e.code || key_extended != e.ext))) begin
          n_err++;
          $display("FAIL strobe: got err=%0b code=0x%0h ext=%0b expected err=%0b code=0x%0h ext=%0b",
                   frame_err, key_code, key_extended, e.is_err, e.code, e.ext);
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_key_code", key_code, 0);
    check("reset_ext", key_extended, 0);
    check("reset_valid", key_valid, 0);
    check("reset_err", frame_err, 0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Make code
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 11);
    drain("make_1c");

    // Break sequence: no strobe, code held
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    drain("break_1c");
    @(negedge clk);
    check("break_hold_code", key_code, 8'h1C);

    // Extended make
    push_key(8'h75, 1'b1);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    drain("ext_make");

    // Extended break: no strobe, outputs held
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    drain("ext_break");
    @(negedge clk);
    check("ext_break_code", key_code, 8'h75);
    check("ext_break_ext", key_extended, 1);

    // Plain make after extended sequence clears key_extended
    push_key(8'h29, 1'b0);
    send_frame(8'h29, 1'b0, 11);
    drain("plain_29");

    // Bad parity
`ifdef PS2_PARITY_CHECK_EN
    push_err();
`else
    push_key(8'h1C, 1'b0);
`endif
    send_frame(8'h1C, 1'b1, 11);
    drain("bad_parity");

    // Timeout after 5 bits, then recovery
    push_err();
    send_frame(8'h5A, 1'b0, 5);
    ps2_data = 1'b1;
    repeat (250) @(posedge clk);
    drain("timeout");
    push_key(8'h29, 1'b0);
    send_frame(8'h29, 1'b0, 11);
    drain("after_timeout");

    // 4-cycle clock glitch with data low must not look like a start bit
    ps2_data = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    ps2_data = 1'b1;
    repeat (300) @(posedge clk);
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 11);
    drain("after_glitch");

    // Typematic repeat of the same make-code
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 11);
    drain("typematic");

    // Reset in the middle of a frame
    push_key(8'h75, 1'b1);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    drain("pre_reset");
    send_frame(8'h4D, 1'b0, 5);
    @(posedge clk);
    rst_n    = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_code", key_code, 0);
    check("midreset_ext", key_extended, 0);
    check("midreset_valid", key_valid, 0);
    check("midreset_err", frame_err, 0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 11);
    drain("after_reset");

    repeat (50) @(posedge clk);
    check("final_queue_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
